// File: rtl/o_serializer_pkg.sv
// Shared types and helpers for the WIDTH:1 multi-channel output serializer.
package o_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_MIN  = 2;
  localparam int WIDTH_MAX  = 16;
  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/o_serializer_lane.sv
// One serializer channel: shift register plus registered output bit, steered by the shared FSM.
module o_serializer_lane
  import o_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 0,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             shift,
  input  logic             idle,
  input  logic [WIDTH-1:0] word,
  output logic             q
);

  logic [WIDTH-1:0] shift_reg;
  logic             q_reg;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  // The shifter holds only the bits not yet on q, already aligned to the send edge.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign first_bit  = word[WIDTH-1];
      assign load_rest  = {word[WIDTH-2:0], 1'b0};
      assign next_bit   = shift_reg[WIDTH-1];
      assign shift_rest = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign first_bit  = word[0];
      assign load_rest  = {1'b0, word[WIDTH-1:1]};
      assign next_bit   = shift_reg[0];
      assign shift_rest = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      shift_reg <= '0;
      q_reg     <= IDLE_VAL;
    end else if (load) begin
      shift_reg <= load_rest;
      q_reg     <= first_bit;
    end else if (shift) begin
      shift_reg <= shift_rest;
      q_reg     <= next_bit;
    end else if (idle) begin
      shift_reg <= '0;
      q_reg     <= IDLE_VAL;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/o_serializer.sv
// WIDTH:1 lockstep output serializer with one-word holding register, pause, framing and underrun flag.
module o_serializer
  import o_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   NUM_CH    = 1,
  parameter int   MSB_FIRST = 0,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic                    C,
  input  logic                    R,
  input  logic                    E,
  input  logic [NUM_CH*WIDTH-1:0] D,
  input  logic                    D_VALID,
  output logic                    D_READY,
  output logic [NUM_CH-1:0]       Q,
  output logic                    Q_VALID,
  output logic                    FRAME,
  output logic                    UNDERRUN,
  input  logic                    UNDERRUN_CLR
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_illegal_params
      $error("o_serializer: WIDTH or NUM_CH out of range");
    end
  endgenerate

  logic [NUM_CH*WIDTH-1:0] hold_reg;
  logic                    hold_full_reg;
  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    q_valid_reg, q_valid_next;
  logic                    frame_reg, frame_next;
  logic                    underrun_reg, underrun_next;
  logic                    accept, transfer;
  logic                    load, shift, idle;

  assign D_READY  = !hold_full_reg && !R;
  assign accept   = D_VALID && D_READY;
  assign transfer = hold_full_reg && E && (state_reg == IDLE || cnt_reg == CNT_LAST);

  // accept needs an empty holder and transfer a full one, so they never coincide.
  always_ff @(posedge C) begin
    if (R) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else if (accept) begin
      hold_reg      <= D;
      hold_full_reg <= 1'b1;
    end else if (transfer) begin
      hold_full_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    q_valid_next  = q_valid_reg;
    frame_next    = frame_reg;
    underrun_next = underrun_reg && !UNDERRUN_CLR;
    load          = 1'b0;
    shift         = 1'b0;
    idle          = 1'b0;
    if (transfer) begin
      load         = 1'b1;
      state_next   = SHIFT;
      cnt_next     = '0;
      q_valid_next = 1'b1;
      frame_next   = 1'b1;
    end else if (state_reg == SHIFT && E) begin
      if (cnt_reg != CNT_LAST) begin
        shift      = 1'b1;
        cnt_next   = cnt_reg + CNT_W'(1);
        frame_next = 1'b0;
      end else begin
        idle          = 1'b1;
        state_next    = IDLE;
        q_valid_next  = 1'b0;
        frame_next    = 1'b0;
        underrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      q_valid_reg  <= 1'b0;
      frame_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      q_valid_reg  <= q_valid_next;
      frame_reg    <= frame_next;
      underrun_reg <= underrun_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      o_serializer_lane #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST),
        .IDLE_VAL (IDLE_VAL)
      ) u_lane (
        .clk  (C),
        .srst (R),
        .load (load),
        .shift(shift),
        .idle (idle),
        .word (hold_reg[gi*WIDTH +: WIDTH]),
        .q    (Q[gi])
      );
    end
  endgenerate

  assign Q_VALID  = q_valid_reg;
  assign FRAME    = frame_reg;
  assign UNDERRUN = underrun_reg;

endmodule
